// File: rtl/tcm_arb_pkg.sv
// Shared types for the TCM port arbiter: requester ids, command/response stage records.
// Bus width macros default here when the surrounding build does not provide them.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef BUS_DATA_WIDTH
`define BUS_DATA_WIDTH 128
`endif
`ifndef REG_DATA_WIDTH
`define REG_DATA_WIDTH 32
`endif
`ifndef SIZE_WIDTH
`define SIZE_WIDTH 2
`endif

package tcm_arb_pkg;

  typedef logic [1:0] req_id_t;

  typedef enum logic [1:0] {
    REQ_FETCH       = 2'd0,
    REQ_STBUF_READ  = 2'd1,
    REQ_STBUF_WRITE = 2'd2
  } req_e;

  typedef struct packed {
    logic                       valid;
    req_id_t                    id;
    logic [`ADDR_WIDTH-1:0]     addr;
    logic [`SIZE_WIDTH-1:0]     size;
    logic [`REG_DATA_WIDTH-1:0] wdata;
    logic                       cancelled;
  } tcm_cmd_t;

  // The response stage only needs to know who to ack and whether a flush killed it.
  typedef struct packed {
    logic    valid;
    req_id_t id;
    logic    cancelled;
  } tcm_rsp_t;

  function automatic req_id_t next_id(input req_id_t id);
    return (id >= 2'd2) ? 2'd0 : id + 2'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Three-way round-robin arbiter: combinational rotate from the pointer, pointer
// advances past the winner and holds when nothing is eligible.
module rr_arbiter3
  import tcm_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] eligible,
  output logic       grant_valid,
  output req_id_t    grant_id
);

  req_id_t ptr_reg;
  req_id_t ptr_next;
  req_id_t idx;

  always_comb begin
    grant_valid = 1'b0;
    grant_id    = REQ_FETCH;
    idx         = (ptr_reg > 2'd2) ? 2'd0 : ptr_reg;
    for (int k = 0; k < 3; k++) begin
      if (!grant_valid && eligible[idx]) begin
        grant_valid = 1'b1;
        grant_id    = idx;
      end
      idx = next_id(idx);
    end
  end

  assign ptr_next = grant_valid ? next_id(grant_id) : ptr_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr_reg <= REQ_FETCH;
    else      ptr_reg <= ptr_next;
  end

endmodule

// File: rtl/tcm_port_arbiter.sv
// Shares the single TCM port between fetch, store-buffer read and store-buffer write
// via a grant -> command -> response pipeline. Optional TCM_PORT_ARBITER_STALL_CNT_EN adds wait counters.
module tcm_port_arbiter
  import tcm_arb_pkg::*;
#(
  parameter int NUM_REQ = 3
`ifdef TCM_PORT_ARBITER_STALL_CNT_EN
  ,
  parameter int STALL_CNT_WIDTH = 32
`endif
) (
  input  logic                       clk,
  input  logic                       rst,
`ifdef TCM_PORT_ARBITER_STALL_CNT_EN
  output logic [STALL_CNT_WIDTH-1:0] fetch_stall_cnt,
  output logic [STALL_CNT_WIDTH-1:0] stbuf_read_stall_cnt,
  output logic [STALL_CNT_WIDTH-1:0] stbuf_write_stall_cnt,
`endif
  input  logic [`ADDR_WIDTH-1:0]     fetch_addr,
  input  logic                       fetch_req,
  input  logic                       fetch_flush,
  output logic [`BUS_DATA_WIDTH-1:0] fetch_data,
  output logic                       fetch_ack,
  input  logic [`ADDR_WIDTH-1:0]     stbuf_read_addr,
  input  logic [`SIZE_WIDTH-1:0]     stbuf_read_size,
  input  logic                       stbuf_read_req,
  output logic [`REG_DATA_WIDTH-1:0] stbuf_read_data,
  output logic                       stbuf_read_ack,
  input  logic [`ADDR_WIDTH-1:0]     stbuf_write_addr,
  input  logic [`SIZE_WIDTH-1:0]     stbuf_write_size,
  input  logic [`REG_DATA_WIDTH-1:0] stbuf_write_data,
  input  logic                       stbuf_write_req,
  output logic                       stbuf_write_ack,
  output logic [`ADDR_WIDTH-1:0]     tcm_addr,
  output logic [`SIZE_WIDTH-1:0]     tcm_size,
  output logic [`REG_DATA_WIDTH-1:0] tcm_wdata,
  output logic                       tcm_rd,
  output logic                       tcm_wr,
  input  logic [`BUS_DATA_WIDTH-1:0] tcm_rdata
);

  logic [NUM_REQ-1:0] req_raw;
  logic [NUM_REQ-1:0] req_vec;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] ack;
  logic               grant_valid;
  req_id_t            grant_id;
  tcm_cmd_t           cmd_reg, cmd_next;
  tcm_rsp_t           rsp_reg, rsp_next;

  assign req_raw = {stbuf_write_req, stbuf_read_req, fetch_req};
  // A fetch request seen alongside a flush belongs to the discarded stream.
  assign req_vec = {req_raw[2:1], req_raw[0] & ~fetch_flush};

  // A requester with an access already in the pipe may not be granted again.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign eligible[gi] = req_vec[gi]
                            && !(cmd_reg.valid && cmd_reg.id == req_id_t'(gi))
                            && !(rsp_reg.valid && rsp_reg.id == req_id_t'(gi));
      assign ack[gi]      = rsp_reg.valid && !rsp_reg.cancelled && rsp_reg.id == req_id_t'(gi);
    end
  endgenerate

  rr_arbiter3 u_rr (
    .clk        (clk),
    .rst        (rst),
    .eligible   (eligible),
    .grant_valid(grant_valid),
    .grant_id   (grant_id)
  );

  always_comb begin
    cmd_next = '0;
    if (grant_valid) begin
      cmd_next.valid = 1'b1;
      cmd_next.id    = grant_id;
      case (grant_id)
        REQ_FETCH:      cmd_next.addr = fetch_addr;
        REQ_STBUF_READ: begin
          cmd_next.addr = stbuf_read_addr;
          cmd_next.size = stbuf_read_size;
        end
        REQ_STBUF_WRITE: begin
          cmd_next.addr  = stbuf_write_addr;
          cmd_next.size  = stbuf_write_size;
          cmd_next.wdata = stbuf_write_data;
        end
        default:        cmd_next = '0;
      endcase
    end
  end

  always_comb begin
    rsp_next.valid     = cmd_reg.valid;
    rsp_next.id        = cmd_reg.id;
    rsp_next.cancelled = cmd_reg.cancelled
                         || (fetch_flush && cmd_reg.valid && cmd_reg.id == REQ_FETCH);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_reg <= '0;
      rsp_reg <= '0;
    end else begin
      cmd_reg <= cmd_next;
      rsp_reg <= rsp_next;
    end
  end

  always_comb begin
    tcm_rd = 1'b0;
    tcm_wr = 1'b0;
    if (cmd_reg.valid) begin
      case (cmd_reg.id)
        REQ_FETCH, REQ_STBUF_READ: tcm_rd = 1'b1;
        REQ_STBUF_WRITE:           tcm_wr = 1'b1;
        default:                   ;
      endcase
    end
  end

  assign tcm_addr  = cmd_reg.addr;
  assign tcm_size  = cmd_reg.size;
  assign tcm_wdata = cmd_reg.wdata;

  // A flush arriving in the response cycle still has to swallow that ack.
  assign fetch_ack       = ack[0] && !fetch_flush;
  assign stbuf_read_ack  = ack[1];
  assign stbuf_write_ack = ack[2];
  assign fetch_data      = fetch_ack ? tcm_rdata : '0;
  assign stbuf_read_data = ack[1] ? tcm_rdata[`REG_DATA_WIDTH-1:0] : '0;

`ifdef TCM_PORT_ARBITER_STALL_CNT_EN
  logic [STALL_CNT_WIDTH-1:0] stall_cnt_reg [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stall
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          stall_cnt_reg[gi] <= '0;
        end else if (req_raw[gi] && !(grant_valid && grant_id == req_id_t'(gi))
                     && !(&stall_cnt_reg[gi])) begin
          stall_cnt_reg[gi] <= stall_cnt_reg[gi] + 1'b1;
        end
      end
    end
  endgenerate

  assign fetch_stall_cnt       = stall_cnt_reg[0];
  assign stbuf_read_stall_cnt  = stall_cnt_reg[1];
  assign stbuf_write_stall_cnt = stall_cnt_reg[2];
`endif

endmodule

// File: tb/tb_tcm_port_arbiter.sv
// Directed bench for tcm_port_arbiter: reset, single fetch, three-way contention,
// fairness, flush and (with TCM_PORT_ARBITER_STALL_CNT_EN) the stall counters.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef BUS_DATA_WIDTH
`define BUS_DATA_WIDTH 128
`endif
`ifndef REG_DATA_WIDTH
`define REG_DATA_WIDTH 32
`endif
`ifndef SIZE_WIDTH
`define SIZE_WIDTH 2
`endif

module tb_tcm_port_arbiter;

  logic                       clk = 1'b0;
  logic                       rst;
  logic [`ADDR_WIDTH-1:0]     fetch_addr;
  logic                       fetch_req;
  logic                       fetch_flush;
  logic [`BUS_DATA_WIDTH-1:0] fetch_data;
  logic                       fetch_ack;
  logic [`ADDR_WIDTH-1:0]     stbuf_read_addr;
  logic [`SIZE_WIDTH-1:0]     stbuf_read_size;
  logic                       stbuf_read_req;
  logic [`REG_DATA_WIDTH-1:0] stbuf_read_data;
  logic                       stbuf_read_ack;
  logic [`ADDR_WIDTH-1:0]     stbuf_write_addr;
  logic [`SIZE_WIDTH-1:0]     stbuf_write_size;
  logic [`REG_DATA_WIDTH-1:0] stbuf_write_data;
  logic                       stbuf_write_req;
  logic                       stbuf_write_ack;
  logic [`ADDR_WIDTH-1:0]     tcm_addr;
  logic [`SIZE_WIDTH-1:0]     tcm_size;
  logic [`REG_DATA_WIDTH-1:0] tcm_wdata;
  logic                       tcm_rd;
  logic                       tcm_wr;
  logic [`BUS_DATA_WIDTH-1:0] tcm_rdata;
`ifdef TCM_PORT_ARBITER_STALL_CNT_EN
  logic [31:0] fetch_stall_cnt, stbuf_read_stall_cnt, stbuf_write_stall_cnt;
`endif

  localparam logic [127:0] RD0 = 128'habbccdde_12574985_1000203f_abcdef12;
  localparam logic [127:0] RD1 = 128'hacaedffe_1ac1d2e5_1205abcd_fedd1698;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  tcm_port_arbiter dut (
    .clk              (clk),
    .rst              (rst),
`ifdef TCM_PORT_ARBITER_STALL_CNT_EN
    .fetch_stall_cnt      (fetch_stall_cnt),
    .stbuf_read_stall_cnt (stbuf_read_stall_cnt),
    .stbuf_write_stall_cnt(stbuf_write_stall_cnt),
`endif
    .fetch_addr       (fetch_addr),
    .fetch_req        (fetch_req),
    .fetch_flush      (fetch_flush),
    .fetch_data       (fetch_data),
    .fetch_ack        (fetch_ack),
    .stbuf_read_addr  (stbuf_read_addr),
    .stbuf_read_size  (stbuf_read_size),
    .stbuf_read_req   (stbuf_read_req),
    .stbuf_read_data  (stbuf_read_data),
    .stbuf_read_ack   (stbuf_read_ack),
    .stbuf_write_addr (stbuf_write_addr),
    .stbuf_write_size (stbuf_write_size),
    .stbuf_write_data (stbuf_write_data),
    .stbuf_write_req  (stbuf_write_req),
    .stbuf_write_ack  (stbuf_write_ack),
    .tcm_addr         (tcm_addr),
    .tcm_size         (tcm_size),
    .tcm_wdata        (tcm_wdata),
    .tcm_rd           (tcm_rd),
    .tcm_wr           (tcm_wr),
    .tcm_rdata        (tcm_rdata)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp)
      $display("%0t ok   %s = %0h", $time, tag, obs);
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  int ack_cnt [3];
  int last_ack [3];
  logic [2:0] acks;

  initial begin
    rst = 1'b0;
    fetch_addr = '0; fetch_req = 1'b0; fetch_flush = 1'b0;
    stbuf_read_addr = '0; stbuf_read_size = '0; stbuf_read_req = 1'b0;
    stbuf_write_addr = '0; stbuf_write_size = '0; stbuf_write_data = '0; stbuf_write_req = 1'b0;
    tcm_rdata = '0;

    // reset state
    sample();
    check("rst_tcm_rd", tcm_rd, 0);
    check("rst_tcm_wr", tcm_wr, 0);
    check("rst_tcm_addr", tcm_addr, 0);
    check("rst_fetch_ack", fetch_ack, 0);
    tick();

    // single fetch: grant in A, command at A+1, ack at A+2
    tick(); rst = 1'b1; fetch_addr = 'h10; fetch_req = 1'b1; tcm_rdata = RD0;
    sample(); check("a0_tcm_rd", tcm_rd, 0);
    tick(); sample();
    check("a1_tcm_rd", tcm_rd, 1);
    check("a1_tcm_addr", tcm_addr, 'h10);
    check("a1_tcm_size", tcm_size, 0);
    check("a1_fetch_ack", fetch_ack, 0);
    tick(); sample();
    check("a2_fetch_ack", fetch_ack, 1);
    check("a2_fetch_data", fetch_data, RD0);
    check("a2_tcm_rd", tcm_rd, 0);
    tick(); fetch_req = 1'b0; sample();
    check("a3_fetch_ack", fetch_ack, 0);
    check("a3_fetch_data", fetch_data, 0);

    // asynchronous reset with a fetch in the command stage
    tick(); fetch_addr = 'h40; fetch_req = 1'b1;
    tick(); sample();
    check("b1_tcm_rd", tcm_rd, 1);
    check("b1_tcm_addr", tcm_addr, 'h40);
    #1; rst = 1'b0; fetch_req = 1'b0; #1;
    check("brst_tcm_rd", tcm_rd, 0);
    check("brst_tcm_wr", tcm_wr, 0);
    check("brst_tcm_addr", tcm_addr, 0);
    check("brst_fetch_ack", fetch_ack, 0);
    tick(); tick(); rst = 1'b1;
    sample(); check("brel_fetch_ack", fetch_ack, 0);

    // all three at once after reset: fetch, read, write in order
    tick();
    fetch_addr = 'h10; fetch_req = 1'b1;
    stbuf_read_addr = 'h20; stbuf_read_size = 2'b10; stbuf_read_req = 1'b1;
    stbuf_write_addr = 'h30; stbuf_write_size = 2'b10; stbuf_write_data = 'hdeadbeef;
    stbuf_write_req = 1'b1;
    sample(); check("c0_tcm_rd", tcm_rd, 0);
    tick(); sample();
    check("c1_tcm_rd", tcm_rd, 1);
    check("c1_tcm_addr", tcm_addr, 'h10);
    check("c1_tcm_size", tcm_size, 0);
    tick(); tcm_rdata = RD0; sample();
    check("c2_tcm_rd", tcm_rd, 1);
    check("c2_tcm_addr", tcm_addr, 'h20);
    check("c2_tcm_size", tcm_size, 2'b10);
    check("c2_fetch_ack", fetch_ack, 1);
    check("c2_fetch_data", fetch_data, RD0);
    tick(); fetch_req = 1'b0; tcm_rdata = RD1; sample();
    check("c3_tcm_wr", tcm_wr, 1);
    check("c3_tcm_rd", tcm_rd, 0);
    check("c3_tcm_wdata", tcm_wdata, 'hdeadbeef);
    check("c3_tcm_addr", tcm_addr, 'h30);
    check("c3_tcm_size", tcm_size, 2'b10);
    check("c3_rd_ack", stbuf_read_ack, 1);
    check("c3_rd_data", stbuf_read_data, 'hfedd1698);
    check("c3_fetch_ack", fetch_ack, 0);
    tick(); stbuf_read_req = 1'b0; sample();
    check("c4_wr_ack", stbuf_write_ack, 1);
    check("c4_rd_ack", stbuf_read_ack, 0);
    check("c4_rd_data", stbuf_read_data, 0);
    check("c4_tcm_wr", tcm_wr, 0);
    check("c4_tcm_rd", tcm_rd, 0);
    tick(); stbuf_write_req = 1'b0; sample();
    check("c5_wr_ack", stbuf_write_ack, 0);

    // fairness: 30 cycles of full contention, acks counted until the pipe drains
    tick();
    fetch_req = 1'b1; stbuf_read_req = 1'b1; stbuf_write_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ack_cnt[i]  = 0;
      last_ack[i] = -1;
    end
    for (int c = 0; c < 32; c++) begin
      sample();
      acks = {stbuf_write_ack, stbuf_read_ack, fetch_ack};
      check("fair_onehot", ($countones(acks) <= 1), 1);
      for (int i = 0; i < 3; i++) begin
        if (acks[i]) begin
          if (last_ack[i] >= 0) check("fair_gap", c - last_ack[i], 3);
          last_ack[i] = c;
          ack_cnt[i]++;
        end
      end
      tick();
      if (c == 29) begin
        fetch_req = 1'b0; stbuf_read_req = 1'b0; stbuf_write_req = 1'b0;
      end
    end
    check("fair_fetch_cnt", ack_cnt[0], 10);
    check("fair_read_cnt", ack_cnt[1], 10);
    check("fair_write_cnt", ack_cnt[2], 10);

    // flush during the command stage
    fetch_addr = 'h50; fetch_req = 1'b1; stbuf_read_addr = 'h60; stbuf_read_req = 1'b1;
    sample();
    tick(); fetch_flush = 1'b1; fetch_req = 1'b0; sample();
    check("e1_tcm_rd", tcm_rd, 1);
    check("e1_tcm_addr", tcm_addr, 'h50);
    tick(); fetch_flush = 1'b0; sample();
    check("e2_fetch_ack", fetch_ack, 0);
    check("e2_fetch_data", fetch_data, 0);
    check("e2_tcm_rd", tcm_rd, 1);
    check("e2_tcm_addr", tcm_addr, 'h60);
    tick(); fetch_addr = 'h70; fetch_req = 1'b1; tcm_rdata = RD1; sample();
    check("e3_rd_ack", stbuf_read_ack, 1);
    check("e3_rd_data", stbuf_read_data, 'hfedd1698);
    check("e3_fetch_ack", fetch_ack, 0);
    tick(); stbuf_read_req = 1'b0; sample();
    check("e4_tcm_rd", tcm_rd, 1);
    check("e4_tcm_addr", tcm_addr, 'h70);
    tick(); tcm_rdata = RD0; sample();
    check("e5_fetch_ack", fetch_ack, 1);
    check("e5_fetch_data", fetch_data, RD0);

    // a fetch request seen together with flush is not granted
    tick(); fetch_flush = 1'b1; sample();
    tick(); fetch_flush = 1'b0; sample();
    check("f1_tcm_rd", tcm_rd, 0);
    tick(); sample();
    check("f2_tcm_rd", tcm_rd, 1);
    tick(); sample();
    check("f3_fetch_ack", fetch_ack, 1);
    tick(); fetch_req = 1'b0;

`ifdef TCM_PORT_ARBITER_STALL_CNT_EN
    // stall counters: pointer moved to 1 by one fetch, then fetch + write contend
    rst = 1'b0;
    tick(); rst = 1'b1; fetch_req = 1'b1;
    tick(); fetch_req = 1'b0;
    tick();
    tick(); fetch_req = 1'b1; stbuf_write_req = 1'b1; sample();
    check("g0_fetch_stall", fetch_stall_cnt, 0);
    check("g0_write_stall", stbuf_write_stall_cnt, 0);
    tick(); sample();
    check("g1_tcm_wr", tcm_wr, 1);
    tick(); tick(); tick(); tick(); sample();
    check("g5_fetch_stall", fetch_stall_cnt, 3);
    check("g5_write_stall", stbuf_write_stall_cnt, 3);
    check("g5_read_stall", stbuf_read_stall_cnt, 0);
    tick(); fetch_req = 1'b0; stbuf_write_req = 1'b0;
`endif

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tcm_port_arbiter.md
Name: tcm_port_arbiter

Overview:
Shares the single-ported TCM between three requesters: instruction fetch read, store-buffer read and store-buffer write. Sits between the bus address decode and the TCM macro, and receives TCM-relative addresses from the bus. Uses round-robin grant with a 2-stage pipeline (command, response), so the TCM port can accept one access per cycle. Each requester sees a level-request / pulse-ack handshake.

Parameters:
NUM_REQ, 3, requester count; index 0 = fetch, 1 = stbuf read, 2 = stbuf write; fixed at 3.
STALL_CNT_WIDTH, 32, width of each wait-cycle counter (optional feature only).

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
fetch_addr  in  `ADDR_WIDTH  fetch read address, TCM-relative
fetch_req  in  1  fetch read request, held until ack
fetch_flush  in  1  cancel the in-flight fetch; its ack is suppressed
fetch_data  out  `BUS_DATA_WIDTH  fetch read data, valid with fetch_ack
fetch_ack  out  1  one-cycle completion pulse
stbuf_read_addr  in  `ADDR_WIDTH  store-buffer read address
stbuf_read_size  in  `SIZE_WIDTH  store-buffer read size
stbuf_read_req  in  1  store-buffer read request
stbuf_read_data  out  `REG_DATA_WIDTH  tcm_rdata[`REG_DATA_WIDTH-1:0], valid with ack
stbuf_read_ack  out  1  one-cycle completion pulse
stbuf_write_addr  in  `ADDR_WIDTH  store-buffer write address
stbuf_write_size  in  `SIZE_WIDTH  store-buffer write size
stbuf_write_data  in  `REG_DATA_WIDTH  store-buffer write data
stbuf_write_req  in  1  store-buffer write request
stbuf_write_ack  out  1  one-cycle completion pulse
tcm_addr  out  `ADDR_WIDTH  registered TCM command address
tcm_size  out  `SIZE_WIDTH  registered size; 0 for fetch
tcm_wdata  out  `REG_DATA_WIDTH  registered write data
tcm_rd  out  1  registered read strobe
tcm_wr  out  1  registered write strobe
tcm_rdata  in  `BUS_DATA_WIDTH  TCM read data, valid the cycle after tcm_rd

Behaviour:
- Reset (rst low, asynchronous): every output 0; cmd_valid = 0, rsp_valid = 0; round-robin pointer = 0 (fetch).
- Eligible[i] = req[i] AND NOT (cmd_valid AND cmd_id == i) AND NOT (rsp_valid AND rsp_id == i).
- Grant in cycle N: the first eligible index at or after the pointer, searching modulo 3. Pointer then becomes (grant + 1) mod 3. With no eligible request, the pointer holds.
- Cycle N+1 (command stage): registers drive tcm_* for the grant. tcm_rd = 1 for ids 0/1; tcm_wr = 1 for id 2. Exactly one of tcm_rd/tcm_wr is high when cmd_valid; both are 0 otherwise.
- Cycle N+2 (response stage): ack[rsp_id] = 1 for one cycle.
  - Fetch: fetch_data = tcm_rdata.
  - Stbuf read: stbuf_read_data = low word of tcm_rdata.
  - Write: ack only.
  - Data outputs are 0 when their ack is low.
- Throughput: one TCM command per cycle across requesters. A single requester completes at most one access every 3 cycles. After its ack, a requester must drop its request or present the next one in cycle N+3.
- Latency: request to ack is 2 cycles when uncontended. With all three requesting continuously, each requester is served every 3 cycles.
- fetch_flush high:
  - Any fetch in the command or response stage is marked cancelled; fetch_ack stays 0 for it. The TCM read still completes.
  - A fetch_req sampled in the same cycle as flush is not granted.
- Simultaneous stbuf read and write to the same address: granted in round-robin order with no reordering. Hazard ordering is the store buffer's responsibility.
- Request dropped after grant, with no flush: the transaction still completes and is acked.
- No illegal states exist. Ids outside 0..2 are unreachable; the default decode forces idle.

Optional Feature:
Macro TCM_PORT_ARBITER_STALL_CNT_EN.
- Defined: adds three outputs, fetch_stall_cnt, stbuf_read_stall_cnt and stbuf_write_stall_cnt, each STALL_CNT_WIDTH wide.
  - Each counter increments in every cycle its req is high and it is not granted.
  - Counters saturate at all-ones and reset to 0.
- Not defined: these ports and the counter logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package (tcm_arb_pkg): requester id enum (REQ_FETCH = 0, REQ_STBUF_READ = 1, REQ_STBUF_WRITE = 2), 2-bit id type, and a packed command struct {valid, id, addr, size, wdata, cancelled}.
- Sub-module: rr_arbiter3 (combinational priority rotate plus pointer register), reusable for other shared ports.

Test Plan:
- Reset: hold rst low mid-traffic with a fetch in the command stage -> all acks, tcm_rd and tcm_wr drop to 0 immediately; after release, the first grant goes to fetch.
- Single fetch: fetch_addr = 'h10, fetch_req = 1; tcm_rdata = 'habbccdde_12574985_1000203f_abcdef12 -> tcm_rd = 1 and tcm_addr = 'h10 at +1; fetch_ack = 1 with that data at +2.
- All three requesting at once: addresses 'h10 / 'h20 / 'h30, write data 'hdeadbeef, write size 'b10 -> grant order fetch, stbuf read, stbuf write on consecutive cycles. tcm_wr = 1 with tcm_wdata = 'hdeadbeef at +3. Stbuf read data = 'hfedd1698 when tcm_rdata = 'hacaedffe_1ac1d2e5_1205abcd_fedd1698.
- Fairness: all requests held high for 30 cycles -> each ack pulses 10 times, every 3 cycles, and no requester has two acks within 3 cycles.
- Flush: fetch granted, then fetch_flush = 1 in the command cycle -> fetch_ack stays 0, an in-flight stbuf read still acks, and the next fetch request is acked normally.
- With TCM_PORT_ARBITER_STALL_CNT_EN: fetch and stbuf write requested together for 6 cycles, pointer at 1 -> stbuf write is granted first; fetch_stall_cnt ends at 3 and stbuf_write_stall_cnt at 3.
